// File: rtl/calc_pkg.sv
// Shared constants for the two-function calculator core: state encodings,
// operation codes and the default datapath width.
package calc_pkg;

   localparam int unsigned CALC_W = 8;

   typedef logic [1:0] calc_state_t;

   localparam calc_state_t S_WAIT_A = 2'b00;
   localparam calc_state_t S_WAIT_B = 2'b01;
   localparam calc_state_t S_SHOW   = 2'b10;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/calc_if.sv
// Switch/key inputs and display/status outputs of the calculator core,
// bundled so the front panel and the core connect through one port.
interface calc_if
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = CALC_W
) ();

   logic [WIDTH-1:0] sw;
   logic             enter;
   logic             op;
   logic [WIDTH-1:0] tc;
   logic             ovf;
   calc_state_t      state;
   logic             op_led;

   modport master (
      output sw, enter, op,
      input  tc, ovf, state, op_led
   );

   modport slave (
      input  sw, enter, op,
      output tc, ovf, state, op_led
   );

endinterface

// File: rtl/key_edge.sv
// Multi-flop synchronizer with a rising-edge detector on the synchronized
// output; a level held high yields a single one-cycle rise pulse.
module key_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q_sync,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign q_sync = sync_q[SYNC_STAGES-1];
   assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/calc_core.sv
// Calculator front end: captures A, then B and the operation on ENTER presses,
// and presents a live operand preview or the add/subtract result with overflow.
module calc_core
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH       = CALC_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic  clk,
   input logic  reset,
   calc_if.slave io
);

   localparam int unsigned Msb = WIDTH - 1;

   logic             enter_pulse;
   logic             enter_sync;
   logic             op_sync;
   logic             op_rise;
   logic             unused_sigs;

   logic [WIDTH-1:0] sw_q;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             op_led_q, op_led_d;
   calc_state_t      state_q, state_d;

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;
   logic             sum_ovf;

   key_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_enter_edge (
      .clk   (clk),
      .reset (reset),
      .d     (io.enter),
      .q_sync(enter_sync),
      .rise  (enter_pulse)
   );

   key_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_op_sync (
      .clk   (clk),
      .reset (reset),
      .d     (io.op),
      .q_sync(op_sync),
      .rise  (op_rise)
   );

   assign unused_sigs = enter_sync ^ op_rise;

   // Subtract as A + ~B + 1; B is the switch value at the moment of the press.
   always_comb begin
      b_eff = (op_sync == OP_SUB) ? ~sw_q : sw_q;
      sum   = a_q + b_eff + {{(WIDTH-1){1'b0}}, op_sync};
      if (op_sync == OP_SUB) begin
         sum_ovf = (a_q[Msb] != sw_q[Msb]) && (sum[Msb] != a_q[Msb]);
      end else begin
         sum_ovf = (a_q[Msb] == sw_q[Msb]) && (sum[Msb] != a_q[Msb]);
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      tc_d     = tc_q;
      ovf_d    = ovf_q;
      op_led_d = op_led_q;
      case (state_q)
         S_WAIT_A: begin
            tc_d = sw_q;
            if (enter_pulse) begin
               a_d     = sw_q;
               state_d = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            tc_d = sw_q;
            if (enter_pulse) begin
               tc_d     = sum;
               ovf_d    = sum_ovf;
               op_led_d = op_sync;
               state_d  = S_SHOW;
            end
         end
         S_SHOW: begin
            if (enter_pulse) begin
               ovf_d   = 1'b0;
               state_d = S_WAIT_A;
            end
         end
         default: begin
            ovf_d   = 1'b0;
            state_d = S_WAIT_A;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_q     <= '0;
         a_q      <= '0;
         tc_q     <= '0;
         ovf_q    <= 1'b0;
         op_led_q <= 1'b0;
         state_q  <= S_WAIT_A;
      end else begin
         sw_q     <= io.sw;
         a_q      <= a_d;
         tc_q     <= tc_d;
         ovf_q    <= ovf_d;
         op_led_q <= op_led_d;
         state_q  <= state_d;
      end
   end

   assign io.tc     = tc_q;
   assign io.ovf    = ovf_q;
   assign io.state  = state_q;
   assign io.op_led = op_led_q;

endmodule

// File: tb/tb_calc_core.sv
// Bench for calc_core: directed operand/operation entries push expected results
// to a queue; a monitor pops and compares each time the core enters SHOW.
module tb_calc_core;
   import calc_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   calc_if #(.WIDTH(8)) bus ();

   calc_core #(
      .WIDTH      (8),
      .SYNC_STAGES(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .io   (bus)
   );

   typedef struct packed {
      logic [7:0] tc;
      logic       ovf;
      logic       op_led;
   } exp_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       op;
      logic [7:0] tc;
      logic       ovf;
   } vec_t;

   int          checks   = 0;
   int          failures = 0;
   exp_t        exp_q[$];
   calc_state_t prev_state;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: a fresh entry into SHOW is the moment a result is presented.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.state == S_SHOW && prev_state != S_SHOW) begin
         if (exp_q.size() == 0) begin
            check("result_pending", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check("result_tc", bus.tc, e.tc);
            check("result_ovf", bus.ovf, e.ovf);
            check("result_op_led", bus.op_led, e.op_led);
         end
      end
      prev_state = bus.state;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press();
      bus.enter = 1'b1;
      cycles(3);
      bus.enter = 1'b0;
      cycles(3);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic op,
                         input logic [7:0] etc, input logic eovf);
      bus.sw = a;
      cycles(3);
      press();
      check("state_wait_b", bus.state, S_WAIT_B);
      bus.sw = b;
      bus.op = op;
      cycles(3);
      exp_q.push_back('{tc: etc, ovf: eovf, op_led: op});
      press();
      check("state_show", bus.state, S_SHOW);
   endtask

   task automatic back_to_a();
      press();
      check("state_wait_a", bus.state, S_WAIT_A);
      check("ovf_cleared", bus.ovf, 1'b0);
   endtask

   vec_t vecs[6] = '{
      '{a: 8'h05, b: 8'h03, op: OP_ADD, tc: 8'h08, ovf: 1'b0},
      '{a: 8'h64, b: 8'h32, op: OP_ADD, tc: 8'h96, ovf: 1'b1},
      '{a: 8'h80, b: 8'h80, op: OP_ADD, tc: 8'h00, ovf: 1'b1},
      '{a: 8'h03, b: 8'h05, op: OP_SUB, tc: 8'hFE, ovf: 1'b0},
      '{a: 8'h80, b: 8'h01, op: OP_SUB, tc: 8'h7F, ovf: 1'b1},
      '{a: 8'h00, b: 8'h80, op: OP_SUB, tc: 8'h80, ovf: 1'b1}
   };

   initial begin
      int bad;
      bus.sw    = 8'h55;
      bus.enter = 1'b0;
      bus.op    = 1'b0;
      reset     = 1'b1;
      cycles(2);
      check("reset_tc", bus.tc, 8'h00);
      check("reset_ovf", bus.ovf, 1'b0);
      check("reset_state", bus.state, S_WAIT_A);
      check("reset_op_led", bus.op_led, 1'b0);

      reset = 1'b0;
      cycles(1);
      check("preview_1_edge", bus.tc, 8'h00);
      cycles(1);
      check("preview_2_edges", bus.tc, 8'h55);

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tc, vecs[i].ovf);
         back_to_a();
         if (i == 0) check("tc_resume", bus.tc, 8'h03);
      end

      // ENTER held high: latency to WAIT_B and exactly one transition.
      bus.op = OP_ADD;
      bus.sw = 8'h10;
      cycles(3);
      bus.enter = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("latency_edge_k", bus.state, S_WAIT_A);
      @(posedge clk);
      @(negedge clk);
      check("latency_edge_k1", bus.state, S_WAIT_A);
      @(posedge clk);
      @(negedge clk);
      check("latency_edge_k2", bus.state, S_WAIT_B);
      bad = 0;
      repeat (197) begin
         cycles(1);
         if (bus.state != S_WAIT_B) bad++;
      end
      check("hold_single_pulse", bad, 0);
      bus.enter = 1'b0;
      cycles(3);
      bus.sw = 8'h07;
      cycles(3);
      exp_q.push_back('{tc: 8'h17, ovf: 1'b0, op_led: 1'b0});
      press();
      check("hold_show", bus.state, S_SHOW);

      // OP and SW activity while showing must not disturb the result.
      bus.op = 1'b1;
      cycles(4);
      bus.op = 1'b0;
      cycles(4);
      bus.op = 1'b1;
      bus.sw = 8'h99;
      cycles(4);
      check("show_hold_tc", bus.tc, 8'h17);
      check("show_hold_op_led", bus.op_led, 1'b0);
      check("show_hold_state", bus.state, S_SHOW);
      bus.op = 1'b0;
      back_to_a();

      // Asynchronous reset in WAIT_B, then a fresh entry.
      bus.sw = 8'h7F;
      cycles(3);
      press();
      check("mid_wait_b", bus.state, S_WAIT_B);
      check("mid_preview", bus.tc, 8'h7F);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_state", bus.state, S_WAIT_A);
      check("async_reset_tc", bus.tc, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      run_op(8'h01, 8'h01, OP_ADD, 8'h02, 1'b0);
      back_to_a();

      cycles(5);
      check("pending_results", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/calc_core.md
Name: calc_core

Overview:
- Sequential operand/operation front end of the two-function calculator: captures operand A, operand B and the add/subtract selection from switches and a single ENTER key.
- Computes the 8-bit two's-complement sum or difference and flags signed overflow.
- Drives the TC bus consumed directly by the output unit (sign LED + three-digit magnitude display). TC shows a live operand preview while operands are being entered, then holds the result.

Parameters:
- WIDTH, 8, operand/result width in bits. The display path supports only 8; other values are not supported.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on ENTER and OP (minimum 2).

Ports:
- clk  in  1  system clock (50 MHz board clock)
- reset  in  1  asynchronous, active-high reset
- SW  in  WIDTH  operand value, two's complement, quasi-static slide switches
- ENTER  in  1  active-high, externally debounced key; each 0->1 transition is one press
- OP  in  1  operation select: 0 = add (A+B), 1 = subtract (A-B)
- TC  out  WIDTH  registered two's-complement value to the output unit
- OVF  out  1  registered signed-overflow flag for the current result
- STATE  out  2  registered FSM state for status LEDs: 00 = WAIT_A, 01 = WAIT_B, 10 = SHOW
- OP_LED  out  1  registered copy of the OP value latched with the result

Behaviour:
- Reset, asynchronous, takes effect immediately, including mid-operation:
  - STATE = WAIT_A; TC, OVF, OP_LED, A register and sw_q all 0; synchronizer and edge flops all 0.
- Input conditioning:
  - SW is registered once into sw_q every cycle.
  - ENTER and OP each pass through SYNC_STAGES flops.
  - enter_pulse = synced ENTER AND NOT its previous-cycle value.
  - ENTER sampled high at edge k gives enter_pulse high during cycle k+SYNC_STAGES-1. The FSM acts on edge k+SYNC_STAGES.
  - Holding ENTER high produces exactly one pulse. A further press needs ENTER to go low and be seen low by the synchronizer first.
- FSM (advances only on enter_pulse; otherwise holds):
  - WAIT_A: TC <= sw_q every cycle. On pulse: A <= sw_q, go to WAIT_B.
  - WAIT_B: TC <= sw_q every cycle. On pulse: B = sw_q, op = synced OP; TC <= result, OVF <= ovf, OP_LED <= op; go to SHOW.
  - SHOW: TC, OVF, OP_LED hold. On pulse: OVF <= 0, go to WAIT_A. TC resumes tracking sw_q from the next cycle.
  - Unused encoding 11 returns to WAIT_A on the next edge with OVF <= 0.
- Arithmetic, WIDTH-bit modulo:
  - Add: R = A + B.
  - Subtract: R = A + ~B + 1.
  - The result is the wrapped value; there is no saturation.
  - Overflow on add: A[MSB] == B[MSB] and R[MSB] != A[MSB].
  - Overflow on subtract: A[MSB] != B[MSB] and R[MSB] != A[MSB].
- Boundaries:
  - -128 - 1 wraps to +127 with OVF=1.
  - 0 - (-128) = -128 with OVF=1.
  - -128 + -128 = 0 with OVF=1.
- Latency:
  - Preview: TC follows an SW change 2 edges later.
  - Result: TC is valid on the same edge that STATE becomes SHOW.
- OP changes outside the WAIT_B->SHOW edge have no effect on TC or OP_LED.
- Reset asserted in any state discards A and any partial entry.

Decomposition:
- Package calc_pkg:
  - state encoding constants S_WAIT_A = 2'b00, S_WAIT_B = 2'b01, S_SHOW = 2'b10
  - op constants OP_ADD = 1'b0, OP_SUB = 1'b1
  - default width constant CALC_W = 8
- Sub-module key_edge:
  - parameter SYNC_STAGES; ports clk, reset, d, q_sync, rise.
  - Instantiated for ENTER (uses rise) and for OP (uses q_sync).
- Adder/overflow logic stays inline in calc_core.

Test Plan:
- Reset with SW=0x55 -> TC=0x00, OVF=0, STATE=00, OP_LED=0. Release reset: after 2 edges TC=0x55.
- SW=5 press, SW=3 OP=0 press -> STATE=10, TC=0x08, OVF=0, OP_LED=0. Press again -> STATE=00, OVF=0.
- Add overflow and wrap:
  - SW=100 (0x64) press, SW=50 (0x32) OP=0 press -> TC=0x96, OVF=1.
  - SW=0x80 press, SW=0x80 OP=0 press -> TC=0x00, OVF=1.
- Subtract:
  - SW=3 press, SW=5 OP=1 press -> TC=0xFE, OVF=0, OP_LED=1.
  - SW=0x80 press, SW=0x01 OP=1 press -> TC=0x7F, OVF=1.
- ENTER held high 200 cycles in WAIT_A -> exactly one transition, to WAIT_B.
  - ENTER asserted at edge k -> STATE changes at edge k+2 (SYNC_STAGES=2).
  - Toggle OP while in SHOW -> TC and OP_LED unchanged.
- Assert reset between clock edges while in WAIT_B with A=0x7F -> STATE=00 and TC=0 immediately, without waiting for a clock edge.
  - Then enter 1 + 1 -> TC=0x02, confirming A was cleared and re-captured.
